// File: rtl/parity_capture_pipe.sv
// Two-stage valid/ready pipe on a single clock. Stage A captures one selected input channel.
// Stage B reduces that word to one bit and counts delivered ones in a saturating counter.
module parity_capture_pipe #(
  parameter int NCH   = 4,
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*W-1:0]         di,
  input  logic [$clog2(NCH)-1:0]   in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     cap_en,
  input  logic                     out_en,
  input  logic [1:0]               mode,
  output logic                     dco,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         ones_cnt,
  output logic                     sat
);

  localparam int SEL_W = $clog2(NCH);

  logic             r_a_full;
  logic [W-1:0]     r_dao;
  logic             r_dco;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_ones_cnt;
  logic             r_sat;

  logic             w_b_load;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [W-1:0]     w_sel_word;
  logic             w_reduced;
  logic [CNT_W-1:0] w_cnt_next;

  // Stage A may refill in the same cycle it drains, so in_ready sees out_ready/out_en combinationally.
  assign w_b_load = r_a_full & out_en & (~r_out_valid | out_ready);
  assign in_ready = rst & cap_en & (~r_a_full | w_b_load);
  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = r_out_valid & out_ready;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_sel_word = di[W-1:0];
    for (int c = 0; c < NCH; c++) begin
      if (in_sel == SEL_W'(c)) w_sel_word = di[c*W +: W];
    end
  end

  always_comb begin
    w_reduced = 1'b0;
    case (mode)
      2'b00:   w_reduced = ^r_dao;
      2'b01:   w_reduced = ~^r_dao;
      2'b10:   w_reduced = |r_dao;
      default: w_reduced = &r_dao;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_full    <= 1'b0;
      r_dao       <= '0;
      r_dco       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_dao    <= w_sel_word;
        r_a_full <= 1'b1;
      end else if (w_b_load) begin
        r_a_full <= 1'b0;
      end

      if (w_b_load) begin
        r_dco       <= w_reduced;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign w_cnt_next = r_ones_cnt + 1'b1;

  // Clear wins over a same-cycle increment; sat latches when the count first reaches all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ones_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (cnt_clr) begin
      r_ones_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (w_out_hs && r_dco && !(&r_ones_cnt)) begin
      r_ones_cnt <= w_cnt_next;
      if (&w_cnt_next) r_sat <= 1'b1;
    end
  end

  assign dco       = r_dco;
  assign out_valid = r_out_valid;
  assign ones_cnt  = r_ones_cnt;
  assign sat       = r_sat;

endmodule

// File: tb/tb_parity_capture_pipe.sv
// Bench for parity_capture_pipe: a queue-based transaction model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_parity_capture_pipe;

  localparam int NCH   = 4;
  localparam int W     = 2;
  localparam int CNT_W = 2;
  localparam int SEL_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH*W-1:0] di = '0;
  logic [SEL_W-1:0] in_sel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             cap_en = 1'b0;
  logic             out_en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             dco;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] ones_cnt;
  logic             sat;

  always #5 clk = ~clk;

  parity_capture_pipe #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .di(di), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .cap_en(cap_en), .out_en(out_en), .mode(mode), .dco(dco), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .ones_cnt(ones_cnt), .sat(sat)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Model: an ordered queue of items in flight. Results sit ahead of raw words; at most one of each.
  typedef struct {
    bit         is_res;
    bit [W-1:0] val;
  } ent_t;

  ent_t pipe[$];
  int   n_ones   = 0;
  bit   last_bit = 1'b0;

  function automatic bit reduce_word(input bit [W-1:0] w, input bit [1:0] m);
    case (m)
      2'd0:    return ^w;
      2'd1:    return ~^w;
      2'd2:    return |w;
      default: return &w;
    endcase
  endfunction

  function automatic bit has_res();
    return pipe.size() > 0 && pipe[0].is_res;
  endfunction

  function automatic bit has_word();
    return pipe.size() > 0 && !pipe[pipe.size()-1].is_res;
  endfunction

  function automatic bit m_move();
    return has_word() && out_en && (!has_res() || out_ready);
  endfunction

  function automatic bit m_in_ready();
    return rst && cap_en && (!has_word() || m_move());
  endfunction

  always @(posedge clk or negedge rst) begin
    bit         hs, mv, acc;
    bit [1:0]   m;
    int         ch;
    bit [W-1:0] w;
    ent_t       e;
    if (!rst) begin
      pipe.delete();
      n_ones   = 0;
      last_bit = 1'b0;
    end else begin
      hs  = has_res() && out_ready;
      mv  = m_move();
      acc = in_valid && m_in_ready();
      m   = mode;
      ch  = (int'(in_sel) < NCH) ? int'(in_sel) : 0;
      w   = di[ch*W +: W];
      if (hs) begin
        if (pipe[0].val[0]) n_ones++;
        void'(pipe.pop_front());
      end
      if (cnt_clr) n_ones = 0;
      if (mv) begin
        e        = pipe[pipe.size()-1];
        last_bit = reduce_word(e.val, m);
        e.is_res = 1'b1;
        e.val    = W'(last_bit);
        pipe[pipe.size()-1] = e;
      end
      if (acc) begin
        e.is_res = 1'b0;
        e.val    = w;
        pipe.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",  32'(in_ready),  32'(m_in_ready()));
    check("out_valid", 32'(out_valid), 32'(has_res()));
    check("dco",       32'(dco),       32'(last_bit));
    check("ones_cnt",  32'(ones_cnt),  (n_ones > MAXC) ? MAXC : n_ones);
    check("sat",       32'(sat),       32'(n_ones >= MAXC));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_mode(input logic [1:0] w, input logic [1:0] m, input logic e);
    di       = {NCH{w}};
    in_sel   = 2'd1;
    mode     = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check($sformatf("mode%0d_w%b_valid", m, w), 32'(out_valid), 32'd1);
    check($sformatf("mode%0d_w%b_dco", m, w), 32'(dco), 32'(e));
    tick();
  endtask

  logic [1:0] mv_w[10] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
  logic [1:0] mv_m[10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
  logic       mv_e[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #10;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    cap_en = 1'b1; out_en = 1'b1; out_ready = 1'b1;
    #1 check("rst_in_ready_enabled", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    tick();

    // XOR path on channel 2.
    di = 8'b00_01_00_00; in_sel = 2'd2; mode = 2'b00; in_valid = 1'b1;
    tick();
    check("xor_valid_n", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    check("xor_valid_n1", 32'(out_valid), 32'd1);
    check("xor_dco", 32'(dco), 32'd1);
    tick();
    check("xor_ones_cnt", 32'(ones_cnt), 32'd1);
    check("xor_valid_done", 32'(out_valid), 32'd0);

    for (int i = 0; i < 10; i++) send_mode(mv_w[i], mv_m[i], mv_e[i]);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_ones", 32'(ones_cnt), 32'd0);
    check("clr_sat", 32'(sat), 32'd0);

    // Backpressure: two words stall behind out_ready=0, a third is offered but must not load.
    mode = 2'b00; out_ready = 1'b0; in_sel = 2'd0;
    di = 8'b10; in_valid = 1'b1;
    tick();
    di = 8'b11;
    tick();
    di = 8'b01;
    for (int i = 0; i < 5; i++) begin
      check("bp_dco", 32'(dco), 32'd1);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_second_dco", 32'(dco), 32'd0);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_ones", 32'(ones_cnt), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Enables.
    cap_en = 1'b0; in_valid = 1'b1; di = 8'b11; mode = 2'b10;
    #1 check("cap_en_low_ready", 32'(in_ready), 32'd0);
    tick(2);
    check("cap_en_low_valid", 32'(out_valid), 32'd0);
    cap_en = 1'b1; out_en = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(3);
    check("out_en_low_valid", 32'(out_valid), 32'd0);
    check("out_en_low_ready", 32'(in_ready), 32'd0);
    out_en = 1'b1;
    #1 check("out_en_high_ready", 32'(in_ready), 32'd1);
    tick();
    check("out_en_valid", 32'(out_valid), 32'd1);
    check("out_en_dco", 32'(dco), 32'd1);
    tick();
    check("out_en_drained", 32'(out_valid), 32'd0);

    // Counter saturation and clear-vs-increment priority.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    mode = 2'b00; di = 8'b01; in_sel = 2'd0; in_valid = 1'b1;
    tick(5);
    in_valid = 1'b0;
    tick(3);
    check("sat_ones", 32'(ones_cnt), 32'd3);
    check("sat_flag", 32'(sat), 32'd1);
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_inc_ones", 32'(ones_cnt), 32'd0);
    check("clr_inc_sat", 32'(sat), 32'd0);
    check("clr_inc_valid", 32'(out_valid), 32'd0);

    // Mixed traffic against the model.
    for (int i = 0; i < 80; i++) begin
      cap_en    = ($urandom_range(0, 3) != 0);
      out_en    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      di        = NCH*W'($urandom);
      in_sel    = SEL_W'($urandom);
      mode      = 2'($urandom);
      tick();
    end

    // Reset mid-stream with a result pending.
    cnt_clr = 1'b0; cap_en = 1'b1; out_en = 1'b1; out_ready = 1'b0;
    di = 8'b01; in_sel = 2'd0; mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dco", 32'(dco), 32'd0);
    check("mid_rst_ones", 32'(ones_cnt), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("mid_release_ready", 32'(in_ready), 32'd1);
    tick(3);
    check("mid_no_replay", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
